// File: rtl/gamma_dither_out.sv
// Requantizes a 12-bit {R,G,B} gamma stream to 8 bits per channel with 1-D horizontal error diffusion.
// Optional macro GAMMA_DITHER_TEMPORAL_EN seeds each line from a frame counter and line parity.
module gamma_dither_out #(
  parameter int DW_IN  = 12,
  parameter int DW_OUT = 8
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_bypass,
  input  logic                  I_vs,
  input  logic                  I_hs,
  input  logic                  I_de,
  input  logic [3*DW_IN-1:0]    I_data,
  output logic                  O_vs,
  output logic                  O_hs,
  output logic                  O_de,
  output logic [3*DW_OUT-1:0]   O_data
);

  localparam int EW = DW_IN - DW_OUT;
  localparam logic [DW_IN:0] MAX_CODE = {1'b0, {DW_IN{1'b1}}};

  generate
    if (EW < 2) begin : g_bad_ew
      $error("gamma_dither_out: DW_IN-DW_OUT must be at least 2");
    end
  endgenerate

  logic [3*DW_IN-1:0]    data_d1_q, data_d1_d;
  logic                  vs_d1_q, vs_d1_d, hs_d1_q, hs_d1_d;
  logic                  de_d1_q, de_d1_d, bypass_d1_q, bypass_d1_d;
  logic                  vs_d2_q, vs_d2_d, hs_d2_q, hs_d2_d, de_d2_q, de_d2_d;
  logic [3*DW_OUT-1:0]   out_q, out_d;
  logic [2:0][EW-1:0]    err_q, err_d;
  logic [2:0][DW_IN:0]   sum;
  logic [EW-1:0]         seed;
  logic                  line_start;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    data_d1_d   = I_data;
    vs_d1_d     = I_vs;
    hs_d1_d     = I_hs;
    de_d1_d     = I_de;
    bypass_d1_d = I_bypass;
    vs_d2_d     = vs_d1_q;
    hs_d2_d     = hs_d1_q;
    de_d2_d     = de_d1_q;
    line_start  = de_d1_q & ~de_d2_q;
    out_d       = '0;
    err_d       = '0;
    sum         = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum[ch] = {1'b0, data_d1_q[ch*DW_IN +: DW_IN]}
              + (DW_IN+1)'(line_start ? seed : err_q[ch]);
      if (de_d1_q) begin
        if (bypass_d1_q) begin
          out_d[ch*DW_OUT +: DW_OUT] = data_d1_q[ch*DW_IN+EW +: DW_OUT];
        end else if (sum[ch] > MAX_CODE) begin
          // Saturated pixels drop their residual rather than pushing it into the next pixel.
          out_d[ch*DW_OUT +: DW_OUT] = '1;
        end else begin
          out_d[ch*DW_OUT +: DW_OUT] = sum[ch][EW +: DW_OUT];
          err_d[ch]                  = sum[ch][EW-1:0];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      data_d1_q   <= '0;
      vs_d1_q     <= 1'b0;
      hs_d1_q     <= 1'b0;
      de_d1_q     <= 1'b0;
      bypass_d1_q <= 1'b0;
      vs_d2_q     <= 1'b0;
      hs_d2_q     <= 1'b0;
      de_d2_q     <= 1'b0;
      out_q       <= '0;
      err_q       <= '0;
    end else begin
      data_d1_q   <= data_d1_d;
      vs_d1_q     <= vs_d1_d;
      hs_d1_q     <= hs_d1_d;
      de_d1_q     <= de_d1_d;
      bypass_d1_q <= bypass_d1_d;
      vs_d2_q     <= vs_d2_d;
      hs_d2_q     <= hs_d2_d;
      de_d2_q     <= de_d2_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

`ifdef GAMMA_DITHER_TEMPORAL_EN
  logic [1:0] frame_cnt_q, frame_cnt_d;
  logic       line_par_q, line_par_d;

  // A vs rising edge clears the line parity even when a de falling edge lands in the same cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    line_par_d  = line_par_q;
    if (~de_d1_q & de_d2_q) line_par_d = ~line_par_q;
    if (vs_d1_q & ~vs_d2_q) begin
      frame_cnt_d = frame_cnt_q + 2'd1;
      line_par_d  = 1'b0;
    end
    seed = EW'(frame_cnt_q ^ {1'b0, line_par_q}) << (EW-2);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      frame_cnt_q <= '0;
      line_par_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      line_par_q  <= line_par_d;
    end
  end
`else
  assign seed = '0;
`endif

  assign O_vs   = vs_d2_q;
  assign O_hs   = hs_d2_q;
  assign O_de   = de_d2_q;
  assign O_data = out_q;

endmodule

// File: tb/tb_gamma_dither_out.sv
// Self-checking bench for gamma_dither_out: directed scenarios plus a randomized stream against
// a pixel-level reference model of the diffusion rules.
module tb_gamma_dither_out;

  localparam int DW_IN  = 12;
  localparam int DW_OUT = 8;
  localparam int EW     = DW_IN - DW_OUT;

  logic                I_clk = 1'b0;
  logic                I_rst = 1'b1;
  logic                I_bypass = 1'b0;
  logic                I_vs = 1'b0;
  logic                I_hs = 1'b0;
  logic                I_de = 1'b0;
  logic [3*DW_IN-1:0]  I_data = '0;
  logic                O_vs, O_hs, O_de;
  logic [3*DW_OUT-1:0] O_data;

  gamma_dither_out #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_bypass(I_bypass),
    .I_vs(I_vs), .I_hs(I_hs), .I_de(I_de), .I_data(I_data),
    .O_vs(O_vs), .O_hs(O_hs), .O_de(O_de), .O_data(O_data)
  );

  always #5 I_clk = ~I_clk;

  typedef struct packed {
    logic rst, bypass, vs, hs, de;
    logic [3*DW_IN-1:0] data;
  } stim_t;

  typedef struct packed {
    logic vs, hs, de;
    logic [3*DW_OUT-1:0] data;
  } out_t;

  int errors = 0;
  int checks = 0;

  // Reference model state: per-channel residual, counters, previous pixel's de/vs.
  int    res [3];
  int    frame_cnt, line_par;
  bit    prev_de, prev_vs;
  stim_t pend;

  stim_t sq[$];
  out_t  obs_q[$], exp_q[$];

  function automatic void model_reset();
    for (int ch = 0; ch < 3; ch++) res[ch] = 0;
    frame_cnt = 0;
    line_par  = 0;
    prev_de   = 0;
    prev_vs   = 0;
    pend      = '0;
  endfunction

  function automatic int seed_val();
`ifdef GAMMA_DITHER_TEMPORAL_EN
    return ((frame_cnt ^ line_par) & 3) << (EW - 2);
`else
    return 0;
`endif
  endfunction

  // Output for one input pixel, following the diffusion rules directly on integers.
  function automatic out_t model_process(stim_t s);
    out_t r;
    int   d, e, sm, o;
    bit   ls;
    r      = '0;
    r.vs   = s.vs;
    r.hs   = s.hs;
    r.de   = s.de;
    ls     = s.de && !prev_de;
    for (int ch = 0; ch < 3; ch++) begin
      o = 0;
      if (!s.de) begin
        res[ch] = 0;
      end else begin
        d = int'(s.data[ch*DW_IN +: DW_IN]);
        if (s.bypass) begin
          o       = d / 16;
          res[ch] = 0;
        end else begin
          e  = ls ? seed_val() : res[ch];
          sm = d + e;
          if (sm > 4095) begin
            o       = 255;
            res[ch] = 0;
          end else begin
            o       = sm / 16;
            res[ch] = sm % 16;
          end
        end
      end
      r.data[ch*DW_OUT +: DW_OUT] = 8'(o);
    end
    if (s.vs && !prev_vs) begin
      frame_cnt = (frame_cnt + 1) % 4;
      line_par  = 0;
    end else if (!s.de && prev_de) begin
      line_par = line_par ^ 1;
    end
    prev_de = s.de;
    prev_vs = s.vs;
    return r;
  endfunction

  function automatic stim_t pix(logic [DW_IN-1:0] v, logic bp);
    stim_t s;
    s        = '0;
    s.de     = 1'b1;
    s.bypass = bp;
    s.data   = {3{v}};
    return s;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rst_s();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  // Drive one cycle, advance the model by one edge, sample 1 time unit after the edge.
  task automatic step(input stim_t s);
    out_t ex;
    I_rst    = s.rst;
    I_bypass = s.bypass;
    I_vs     = s.vs;
    I_hs     = s.hs;
    I_de     = s.de;
    I_data   = s.data;
    @(posedge I_clk);
    if (s.rst) begin
      model_reset();
      ex = '0;
    end else begin
      ex   = model_process(pend);
      pend = s;
    end
    #1;
    obs_q.push_back({O_vs, O_hs, O_de, O_data});
    exp_q.push_back(ex);
  endtask

  task automatic run_seq();
    obs_q.delete();
    exp_q.delete();
    foreach (sq[i]) step(sq[i]);
    sq.delete();
  endtask

  task automatic test_reset();
    stim_t s;
    for (int i = 0; i < 3; i++) begin
      s        = '0;
      s.rst    = 1'b1;
      s.vs     = 1'b1;
      s.hs     = 1'b1;
      s.de     = 1'b1;
      s.data   = {$urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095)};
      sq.push_back(s);
    end
    sq.push_back(pix(12'd2056, 1'b0));
    sq.push_back(pix(12'd2056, 1'b0));
    sq.push_back(idle());
    sq.push_back(idle());
    run_seq();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_q[k] !== out_t'(0)) begin
        errors++;
        $display("FAIL reset_hold k=%0d got=%h exp=0", k, obs_q[k]);
      end
    end
    for (int k = 4; k < 6; k++) begin
      checks++;
      if (obs_q[k].data !== {3{(k == 4) ? 8'd128 : 8'd129}}) begin
        errors++;
        $display("FAIL reset_release k=%0d got=%h", k, obs_q[k].data);
      end
    end
    foreach (obs_q[k]) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL reset_model k=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_diffusion();
    logic [7:0] v;
    sq.push_back(rst_s());
    repeat (8) sq.push_back(pix(12'd2056, 1'b0));
    repeat (3) sq.push_back(idle());
    run_seq();
    foreach (obs_q[k]) begin
      checks++;
      if (obs_q[k].de !== ((k >= 2 && k <= 9) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL diffusion_de k=%0d got=%b", k, obs_q[k].de);
      end
      if (k >= 2 && k <= 9) begin
        v = ((k - 2) % 2 == 0) ? 8'd128 : 8'd129;
        checks++;
        if (obs_q[k].data !== {3{v}}) begin
          errors++;
          $display("FAIL diffusion_data k=%0d got=%h exp=%h", k, obs_q[k].data, {3{v}});
        end
      end
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL diffusion_model k=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] want [3];
    want[0] = 8'd255;
    want[1] = 8'd255;
    want[2] = 8'd1;
    sq.push_back(rst_s());
    sq.push_back(pix(12'd4091, 1'b0));
    sq.push_back(pix(12'd4095, 1'b0));
    sq.push_back(pix(12'd16, 1'b0));
    sq.push_back(idle());
    sq.push_back(idle());
    run_seq();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q[i+2].data !== {3{want[i]}}) begin
        errors++;
        $display("FAIL saturation px=%0d got=%h exp=%h", i, obs_q[i+2].data, {3{want[i]}});
      end
    end
    foreach (obs_q[k]) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL saturation_model k=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_line_boundary();
    sq.push_back(rst_s());
    repeat (3) sq.push_back(pix(12'd2056, 1'b0));
    repeat (5) sq.push_back(idle());
    sq.push_back(pix(12'd2056, 1'b0));
    sq.push_back(idle());
    sq.push_back(idle());
    run_seq();
    checks++;
    if (obs_q[4].data !== {3{8'd128}}) begin
      errors++;
      $display("FAIL line_end got=%h exp=%h", obs_q[4].data, {3{8'd128}});
    end
    checks++;
    if (obs_q[10].data !== {3{8'd128}}) begin
      errors++;
      $display("FAIL line_restart got=%h exp=%h", obs_q[10].data, {3{8'd128}});
    end
    foreach (obs_q[k]) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL line_model k=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] v;
    sq.push_back(rst_s());
    repeat (4) sq.push_back(pix(12'd2063, 1'b1));
    repeat (2) sq.push_back(pix(12'd2056, 1'b0));
    sq.push_back(idle());
    sq.push_back(idle());
    run_seq();
    for (int k = 2; k <= 7; k++) begin
      v = (k == 7) ? 8'd129 : 8'd128;
      checks++;
      if (obs_q[k].data !== {3{v}}) begin
        errors++;
        $display("FAIL bypass k=%0d got=%h exp=%h", k, obs_q[k].data, {3{v}});
      end
    end
    foreach (obs_q[k]) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL bypass_model k=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

`ifdef GAMMA_DITHER_TEMPORAL_EN
  task automatic test_temporal();
    stim_t s;
    logic [7:0] v;
    sq.push_back(rst_s());
    s    = idle();
    s.vs = 1'b1;
    sq.push_back(s);
    sq.push_back(idle());
    sq.push_back(idle());
    repeat (3) sq.push_back(pix(12'd2056, 1'b0));
    sq.push_back(idle());
    sq.push_back(idle());
    run_seq();
    for (int k = 5; k <= 7; k++) begin
      v = (k == 6) ? 8'd129 : 8'd128;
      checks++;
      if (obs_q[k].data !== {3{v}}) begin
        errors++;
        $display("FAIL temporal k=%0d got=%h exp=%h", k, obs_q[k].data, {3{v}});
      end
    end
    foreach (obs_q[k]) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL temporal_model k=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    stim_t s;
    bit    de_state;
    logic [DW_IN-1:0] ch_v;
    de_state = 0;
    step(rst_s());
    for (int n = 0; n < 1500; n++) begin
      s = '0;
      s.rst = ($urandom_range(0, 299) == 0);
      s.vs  = ($urandom_range(0, 39) == 0);
      s.hs  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) de_state = !de_state;
      s.de     = de_state;
      s.bypass = ($urandom_range(0, 7) == 0);
      for (int ch = 0; ch < 3; ch++) begin
        ch_v = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4064, 4095))
                                           : 12'($urandom_range(0, 4095));
        s.data[ch*DW_IN +: DW_IN] = ch_v;
      end
      step(s);
      checks++;
      if (obs_q[$] !== exp_q[$]) begin
        errors++;
        $display("FAIL random n=%0d got=%h exp=%h", n, obs_q[$], exp_q[$]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_diffusion();
    test_saturation();
    test_line_boundary();
    test_bypass();
`ifdef GAMMA_DITHER_TEMPORAL_EN
    test_temporal();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gamma_dither_out.md
Name: gamma_dither_out

Overview:
- Downstream stage of the gamma LUT bank in the ISP gamma path.
- Takes the 12-bit gamma-corrected RGB pixel stream and requantizes each channel to 8 bits for HDMI output.
- Requantization uses 1-D horizontal error diffusion, which avoids banding from plain truncation.
- Video timing signals (vs/hs/de) are delayed to stay aligned with the pixel data.

Parameters:
- DW_IN, 12, per-channel input width (gamma LUT output width).
- DW_OUT, 8, per-channel output width.
- EW = DW_IN-DW_OUT, local (derived), residual width. Must be >= 2; elaboration error otherwise.

Ports:
- I_clk  in  1  pixel clock.
- I_rst  in  1  synchronous reset, active-high.
- I_bypass  in  1  1 = plain truncation, no diffusion; sampled per pixel.
- I_vs  in  1  vertical sync, active-high.
- I_hs  in  1  horizontal sync, active-high.
- I_de  in  1  data enable, active-high.
- I_data  in  3*DW_IN  {R,G,B} gamma-corrected pixel.
- O_vs  out  1  I_vs delayed 2 cycles.
- O_hs  out  1  I_hs delayed 2 cycles.
- O_de  out  1  I_de delayed 2 cycles.
- O_data  out  3*DW_OUT  {R,G,B} requantized pixel.

Behaviour:
- One clock domain (I_clk). Reset is synchronous, active-high (I_rst). While I_rst=1 at a clock edge, every register clears:
  - O_vs, O_hs, O_de, O_data = 0.
  - Residuals, frame counter and line parity = 0.
- Reset asserted mid-line takes effect on the next edge. The first pixel after release uses residual 0.
- Pipeline:
  - Stage 1 registers I_data, I_vs, I_hs, I_de, I_bypass and detects the de rising edge (de_d1 & ~de_d2, line start).
  - Stage 2 computes and registers the outputs.
  - Fixed latency of 2 cycles for all outputs. No backpressure; one pixel per clock.
- Per channel, in stage 2 when de_d1=1:
  - err_in = seed if line start, else err_r (EW bits).
  - sum = data + err_in, computed DW_IN+1 bits wide.
  - If sum > 2^DW_IN-1: out = all ones, err_r <= 0 (saturation drops the residual).
  - Otherwise: out = sum[DW_IN-1:EW], err_r <= sum[EW-1:0].
- Bypass: when bypass_d1=1, out = data[DW_IN-1:EW] and err_r <= 0.
- When de_d1=0:
  - O_data = 0.
  - err_r <= 0, so no residual carries across blanking or lines.
- Channels are fully independent, each with its own err_r.
- Counters:
  - frame_cnt (2 bits) increments on the I_vs rising edge and wraps 3->0.
  - line_par toggles on each de falling edge (stage 1) and clears on the I_vs rising edge.
- seed = 0 unless the optional feature is compiled in.
- Simultaneous events: a vs rising edge in the same cycle as a de edge updates both counters. The vs clear of line_par wins over the toggle.

Optional Feature:
- Macro: GAMMA_DITHER_TEMPORAL_EN.
- Defined: line-start seed = {frame_cnt ^ {1'b0,line_par}, {EW-2{1'b0}}}. This gives temporal plus vertical variation of the diffusion phase.
  - Example (EW=4): frame_cnt=1, line_par=0 -> seed=4.
- Undefined: seed is constant 0. frame_cnt and line_par are not synthesized.

Test Plan:
- Reset: hold I_rst=1 for 3 cycles with active stimulus -> O_vs/O_hs/O_de/O_data all 0 throughout.
- Diffusion: one line of 8 pixels, all channels 12'd2056, bypass=0, seed 0 -> O_data channels 128,129,128,129,... (residual alternates 8,0). O_de is high for exactly 8 cycles, starting 2 cycles after I_de.
- Saturation: pixels 12'd4091 then 12'd4095 -> outputs 255 (residual 11), then 255 with residual dropped to 0. Third pixel 12'd16 -> 1.
- Line boundary: line ends with residual 8, 5 blanking cycles, next line first pixel 12'd2056 -> 128 (residual restarted at 0, macro off).
- Bypass: I_bypass=1, pixels 12'd2063 x4 -> 128 each. Drop bypass mid-line on 12'd2056 -> diffusion restarts from residual 0: 128,129.
- Temporal (macro on): frame_cnt=1 (after one vs pulse), line_par=0, constant 12'd2056 -> first outputs 128 (residual 12), 129 (residual 4), 128 (residual 12).
